// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: forwards message beats, then 0x80, zero fill
// and the 64-bit big-endian bit length, with block/message framing flags.
module sha256_msg_padder #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [$clog2(DATA_W/8):0] in_nbytes,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_sob,
   output logic                      out_eob,
   output logic                      out_first,
   output logic                      out_last,
   output logic                      busy
);
   localparam int NB        = DATA_W / 8;
   localparam int NBW       = $clog2(NB) + 1;
   localparam int BPB       = 512 / DATA_W;
   localparam int LEN_BEATS = 64 / DATA_W;
   localparam int BCW       = $clog2(BPB);
   localparam int CW        = LEN_W - 3;
   localparam logic [BCW-1:0] LEN_PRE  = BCW'(BPB - LEN_BEATS - 1);
   localparam logic [BCW-1:0] LAST_IDX = BCW'(BPB - 1);
   localparam logic [NBW-1:0] NB_V     = NBW'(NB);

   typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD80, S_ZERO, S_LEN} state_t;

   state_t            state_q, state_d;
   logic [BCW-1:0]    beat_cnt_q;
   logic [CW-1:0]     byte_cnt_q;
   logic              blk0_q, busy_q;
   logic [DATA_W-1:0] data_q, data_d, ins_data, len_data;
   logic              valid_q, sob_q, eob_q, first_q, last_q, last_d;
   logic              load, acc, emit, fill, done, first_c;
   logic [63:0]       len64;
   logic [BCW-1:0]    len_rem;

   assign load     = !valid_q || out_ready;
   assign in_ready = !reset && load && (state_q == S_IDLE || state_q == S_DATA);
   assign acc      = in_valid && in_ready;
   assign done     = (state_q == S_LEN) && last_q && valid_q && out_ready;
   assign first_c  = (state_q == S_IDLE) || blk0_q;
   assign len64    = 64'({byte_cnt_q, 3'b000});
   // Length beats occupy the tail of the block; remaining index picks the slice.
   assign len_rem  = LAST_IDX - beat_cnt_q;
   assign len_data = DATA_W'(len64 >> (32'(len_rem) * DATA_W));

   always_comb begin
      ins_data = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < int'(in_nbytes))
            ins_data[DATA_W-1-8*i -: 8] = in_data[DATA_W-1-8*i -: 8];
         else if (i == int'(in_nbytes))
            ins_data[DATA_W-1-8*i -: 8] = 8'h80;
      end
   end

   always_comb begin
      emit    = 1'b0;
      fill    = 1'b0;
      last_d  = 1'b0;
      data_d  = '0;
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DATA: if (acc) begin
            emit = 1'b1;
            if (!in_last) begin
               data_d  = in_data;
               state_d = S_DATA;
            end else if (in_nbytes >= NB_V) begin
               data_d  = in_data;
               state_d = S_PAD80;
            end else begin
               data_d = ins_data;
               fill   = 1'b1;
            end
         end
         S_PAD80: if (load) begin
            emit   = 1'b1;
            data_d = DATA_W'(8'h80) << (DATA_W - 8);
            fill   = 1'b1;
         end
         S_ZERO: if (load) begin
            emit = 1'b1;
            if (beat_cnt_q == LEN_PRE) state_d = S_LEN;
         end
         S_LEN: begin
            if (done) begin
               state_d = S_IDLE;
            end else if (load && !last_q) begin
               emit   = 1'b1;
               data_d = len_data;
               last_d = (beat_cnt_q == LAST_IDX);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (fill) state_d = (beat_cnt_q == LEN_PRE) ? S_LEN : S_ZERO;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         byte_cnt_q <= '0;
         blk0_q     <= 1'b0;
         busy_q     <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sob_q      <= 1'b0;
         eob_q      <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            valid_q <= emit;
            data_q  <= data_d;
            sob_q   <= emit && (beat_cnt_q == '0);
            eob_q   <= emit && (beat_cnt_q == LAST_IDX);
            first_q <= emit && first_c;
            last_q  <= last_d;
         end
         if (emit) begin
            beat_cnt_q <= beat_cnt_q + BCW'(1);
            blk0_q     <= first_c && (beat_cnt_q != LAST_IDX);
         end
         if (acc) begin
            byte_cnt_q <= byte_cnt_q + (in_last ? CW'(in_nbytes) : CW'(NB));
            busy_q     <= 1'b1;
         end
         if (done) begin
            busy_q     <= 1'b0;
            byte_cnt_q <= '0;
            beat_cnt_q <= '0;
         end
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_sob   = sob_q;
   assign out_eob   = eob_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: 8- and 32-bit instances checked against a
// byte-level FIPS 180-4 padding model through per-instance scoreboards.
module tb_sha256_msg_padder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [7:0]  id8, od8;
   logic        iv8, ir8, il8, ov8, or8, sob8, eob8, fst8, lst8, bsy8;
   logic [0:0]  nb8;
   logic [31:0] id32, od32;
   logic        iv32, ir32, il32, ov32, or32, sob32, eob32, fst32, lst32, bsy32;
   logic [2:0]  nb32;

   sha256_msg_padder #(.DATA_W(8), .LEN_W(64)) u8 (
      .clk(clk), .reset(rst),
      .in_data(id8), .in_valid(iv8), .in_ready(ir8),
      .in_last(il8), .in_nbytes(nb8),
      .out_data(od8), .out_valid(ov8), .out_ready(or8),
      .out_sob(sob8), .out_eob(eob8), .out_first(fst8),
      .out_last(lst8), .busy(bsy8));

   sha256_msg_padder #(.DATA_W(32), .LEN_W(32)) u32 (
      .clk(clk), .reset(rst),
      .in_data(id32), .in_valid(iv32), .in_ready(ir32),
      .in_last(il32), .in_nbytes(nb32),
      .out_data(od32), .out_valid(ov32), .out_ready(or32),
      .out_sob(sob32), .out_eob(eob32), .out_first(fst32),
      .out_last(lst32), .busy(bsy32));

   typedef struct packed {
      logic [31:0] data;
      logic        sob;
      logic        eob;
      logic        first;
      logic        last;
   } beat_t;

   typedef struct {
      int w;
      int len;
      int base;
      int step;
      bit tail;
      bit rnd;
      int nout;
   } vec_t;

   beat_t q8[$];
   beat_t q32[$];
   int nvec = 0;
   int nmis = 0;
   int cnt8 = 0;
   int cnt32 = 0;
   bit rnd8 = 1'b0;
   bit rnd32 = 1'b0;

   task automatic push_exp(input int w, input int len, input int base, input int step);
      logic [7:0]  p[$];
      logic [63:0] bits;
      beat_t       e;
      int          nb, bpb, nbeats;
      for (int j = 0; j < len; j++) p.push_back(8'((base + j * step) & 255));
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(len) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
      nb     = w / 8;
      bpb    = 512 / w;
      nbeats = p.size() / nb;
      for (int b = 0; b < nbeats; b++) begin
         e.data = '0;
         for (int i = 0; i < nb; i++) e.data = (e.data << 8) | 32'(p[b*nb+i]);
         e.sob   = (b % bpb == 0);
         e.eob   = (b % bpb == bpb - 1);
         e.first = (b < bpb);
         e.last  = (b == nbeats - 1);
         if (w == 8) q8.push_back(e);
         else q32.push_back(e);
      end
   endtask

   task automatic chk(input int w, input beat_t a);
      beat_t e;
      nvec++;
      if (w == 8) cnt8++;
      else cnt32++;
      if ((w == 8 && q8.size() == 0) || (w == 32 && q32.size() == 0)) begin
         nmis++;
         $display("FAIL w%0d extra-beat: got data=%h, want no beat", w, a.data);
         return;
      end
      if (w == 8) e = q8.pop_front();
      else e = q32.pop_front();
      if (a !== e) begin
         nmis++;
         $display("FAIL w%0d beat: got %h s/e/f/l=%b%b%b%b, want %h s/e/f/l=%b%b%b%b",
                  w, a.data, a.sob, a.eob, a.first, a.last,
                  e.data, e.sob, e.eob, e.first, e.last);
      end
   endtask

   always @(negedge clk)
      if (!rst && ov8 && or8) chk(8, {24'd0, od8, sob8, eob8, fst8, lst8});

   always @(negedge clk)
      if (!rst && ov32 && or32) chk(32, {od32, sob32, eob32, fst32, lst32});

   always @(posedge clk) begin
      #1;
      if (rnd8) or8 = ($urandom_range(0, 3) != 0);
      if (rnd32) or32 = ($urandom_range(0, 3) != 0);
   end

   task automatic wait_acc(input int w);
      int t;
      t = 0;
      @(negedge clk);
      while (!(w == 8 ? ir8 : ir32) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) begin
         nvec++;
         nmis++;
         $display("FAIL w%0d accept-timeout: got in_ready=0, want 1", w);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_msg(input int w, input int len, input int base, input int step,
                           input bit tail);
      int          nb, nbeats, nv;
      logic [31:0] d;
      logic        lst;
      nb = w / 8;
      push_exp(w, len, base, step);
      if (len == 0) nbeats = 1;
      else if (tail) nbeats = len / nb + 1;
      else nbeats = (len + nb - 1) / nb;
      for (int k = 0; k < nbeats; k++) begin
         d = '0;
         for (int i = 0; i < nb; i++)
            d = (d << 8) | ((k * nb + i < len) ? 32'((base + (k*nb+i) * step) & 255) : 32'hEE);
         nv = len - k * nb;
         if (nv > nb) nv = nb;
         if (nv < 0) nv = 0;
         lst = (k == nbeats - 1);
         if (w == 8) begin
            id8 = d[7:0]; il8 = lst; nb8 = 1'(nv); iv8 = 1'b1;
         end else begin
            id32 = d; il32 = lst; nb32 = 3'(nv); iv32 = 1'b1;
         end
         wait_acc(w);
      end
      if (w == 8) begin
         iv8 = 1'b0; il8 = 1'b0;
      end else begin
         iv32 = 1'b0; il32 = 1'b0;
      end
   endtask

   task automatic drain(input int w);
      int t;
      t = 0;
      while (((w == 8) ? q8.size() : q32.size()) != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         nvec++;
         nmis++;
         $display("FAIL w%0d drain-timeout: got %0d beats pending, want 0", w,
                  (w == 8) ? q8.size() : q32.size());
         q8.delete();
         q32.delete();
      end
      @(posedge clk);
      #1;
      nvec++;
      if ((w == 8 ? {bsy8, ov8} : {bsy32, ov32}) !== 2'b00) begin
         nmis++;
         $display("FAIL w%0d idle-after: got busy/valid=%b, want 00", w,
                  (w == 8) ? {bsy8, ov8} : {bsy32, ov32});
      end
   endtask

   task automatic chk_cnt(input string nm, input int got, input int want);
      nvec++;
      if (got != want) begin
         nmis++;
         $display("FAIL %s beat-count: got %0d, want %0d", nm, got, want);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[12];
      int   c0;
      beat_t snap;
      vt = '{
         '{8,   56, 'h30, 0, 1'b0, 1'b0, 128},
         '{8,   55, 'h30, 0, 1'b0, 1'b0, 64},
         '{8,    0, 'h00, 0, 1'b0, 1'b0, 64},
         '{32,   3, 'h61, 1, 1'b0, 1'b0, 16},
         '{8,   64, 'h01, 3, 1'b0, 1'b1, 128},
         '{32,  55, 'h05, 1, 1'b0, 1'b1, 16},
         '{32,  56, 'h09, 1, 1'b0, 1'b0, 32},
         '{32,   8, 'h11, 1, 1'b1, 1'b0, 16},
         '{32,  62, 'h07, 5, 1'b0, 1'b1, 32},
         '{32, 119, 'h02, 3, 1'b0, 1'b0, 32},
         '{32, 121, 'h03, 1, 1'b0, 1'b1, 48},
         '{8,    1, 'hAB, 0, 1'b0, 1'b0, 64}
      };
      rst = 1'b1;
      id8 = '0; iv8 = 1'b0; il8 = 1'b0; nb8 = '0; or8 = 1'b1;
      id32 = '0; iv32 = 1'b0; il32 = 1'b0; nb32 = '0; or32 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({ov8, od8, sob8, eob8, fst8, lst8, bsy8, ir8} !== '0) begin
         nmis++;
         $display("FAIL w8 reset-state: got %b, want 0",
                  {ov8, od8, sob8, eob8, fst8, lst8, bsy8, ir8});
      end
      nvec++;
      if ({ov32, od32, sob32, eob32, fst32, lst32, bsy32, ir32} !== '0) begin
         nmis++;
         $display("FAIL w32 reset-state: got %b, want 0",
                  {ov32, od32, sob32, eob32, fst32, lst32, bsy32, ir32});
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 12; v++) begin
         c0 = (vt[v].w == 8) ? cnt8 : cnt32;
         rnd8  = vt[v].rnd && (vt[v].w == 8);
         rnd32 = vt[v].rnd && (vt[v].w == 32);
         send_msg(vt[v].w, vt[v].len, vt[v].base, vt[v].step, vt[v].tail);
         drain(vt[v].w);
         rnd8 = 1'b0; rnd32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
         chk_cnt($sformatf("vec%0d", v), ((vt[v].w == 8) ? cnt8 : cnt32) - c0, vt[v].nout);
         @(posedge clk);
         #1;
      end

      // Backpressure held for several cycles in the middle of a block.
      c0 = cnt32;
      fork
         send_msg(32, 40, 'h20, 3, 1'b0);
         begin
            repeat (6) @(posedge clk);
            #1;
            or32 = 1'b0;
            @(negedge clk);
            snap = {od32, sob32, eob32, fst32, lst32};
            nvec++;
            if (ov32 !== 1'b1) begin
               nmis++;
               $display("FAIL stall-valid: got out_valid=%b, want 1", ov32);
            end
            repeat (5) begin
               @(negedge clk);
               nvec++;
               if ({od32, sob32, eob32, fst32, lst32} !== snap || ov32 !== 1'b1 || ir32 !== 1'b0) begin
                  nmis++;
                  $display("FAIL stall-hold: got %h v=%b ir=%b, want %h v=1 ir=0",
                           od32, ov32, ir32, snap.data);
               end
            end
            @(posedge clk);
            #1;
            or32 = 1'b1;
         end
      join
      drain(32);
      chk_cnt("stall", cnt32 - c0, 16);

      // Reset while zero fill is in progress, then a fresh message.
      send_msg(32, 3, 'h78, 1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      nvec++;
      if ({ov32, od32, sob32, eob32, fst32, lst32, bsy32, ir32} !== '0) begin
         nmis++;
         $display("FAIL mid-reset: got %b, want 0",
                  {ov32, od32, sob32, eob32, fst32, lst32, bsy32, ir32});
      end
      q32.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      c0 = cnt32;
      send_msg(32, 3, 'h41, 1, 1'b0);
      drain(32);
      chk_cnt("post-reset", cnt32 - c0, 16);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
